candy_sram_arbiter: RTL and testbench

- Shares the single candy SRAM between two requesters:
  - instruction fetch (read-only);
  - data memory stage (read/write).
- Read port: one read per cycle, arbitrated by fixed priority to data with an anti-starvation limit. Write port is separate and serves data writes without contention.
- Sits between the candy core's fetch/mem stages and the top-level sram_raddr/sram_rdata/sram_waddr/sram_wdata pins.
- Tracks in-flight reads and routes each return back to the requester that issued it.

---
 rtl/candy_sram_arbiter_if.sv | 78 +++++++
 rtl/candy_sram_arbiter.sv | 135 +++++++++++++
 tb/tb_candy_sram_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/candy_sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// candy_sram_arbiter_if
//
// Bundles the requester-side handshakes and the SRAM pins of the candy SRAM
// arbiter so that they travel as one port.
//
// Signal groups:
//   fetch   : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   data    : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata
//   sram    : sram_re, sram_raddr, sram_we, sram_waddr, sram_wdata <- sram_rdata
//   perf    : if_stall_cnt, d_stall_cnt (only with CANDY_ARB_PERF_EN defined)
//
// Modports:
//   slave  : arbiter view (requests in, grants/returns/SRAM strobes out)
//   master : environment view (core stages plus SRAM model)
// ---------------------------------------------------------------------------
interface candy_sram_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // data requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // SRAM pins
    logic              sram_re;
    logic [ADDR_W-1:0] sram_raddr;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_waddr;
    logic [DATA_W-1:0] sram_wdata;

`ifdef CANDY_ARB_PERF_EN
    logic [31:0]       if_stall_cnt;
    logic [31:0]       d_stall_cnt;
`endif

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output sram_re, sram_raddr,
        input  sram_rdata,
        output sram_we, sram_waddr, sram_wdata
`ifdef CANDY_ARB_PERF_EN
        ,
        output if_stall_cnt, d_stall_cnt
`endif
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  sram_re, sram_raddr,
        output sram_rdata,
        input  sram_we, sram_waddr, sram_wdata
`ifdef CANDY_ARB_PERF_EN
        ,
        input  if_stall_cnt, d_stall_cnt
`endif
    );

endinterface

// File: rtl/candy_sram_arbiter.sv
// ---------------------------------------------------------------------------
// candy_sram_arbiter
//
// Shares the single candy SRAM between instruction fetch (read-only) and the
// data memory stage (read/write). The read port serves one read per cycle with
// fixed priority to data, bounded by an anti-starvation streak limit so fetch
// always gets through after MAX_DATA_STREAK consecutive data wins. The write
// port is separate, so data writes are granted immediately and may coincide
// with a fetch read. In-flight reads are tracked in a READ_LAT-deep
// {valid, owner} shift register and each return is steered to its issuer.
//
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous reset, active-high
//   bus  : candy_sram_arbiter_if.slave (fetch/data handshakes + SRAM pins)
//
// Parameters:
//   ADDR_W          : SRAM address width
//   DATA_W          : SRAM data width
//   READ_LAT        : cycles from sram_raddr to valid sram_rdata (1..4)
//   MAX_DATA_STREAK : data read wins allowed while fetch waits (1..15)
//
// Optional feature (macro CANDY_ARB_PERF_EN): adds free-running 32-bit stall
// counters if_stall_cnt / d_stall_cnt, counting cycles with req && !gnt.
// ---------------------------------------------------------------------------
module candy_sram_arbiter #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned READ_LAT        = 1,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input logic                 clk,
    input logic                 rst,
    candy_sram_arbiter_if.slave bus
);

    localparam logic [3:0] StreakMax = 4'(MAX_DATA_STREAK);

    logic rd_if;     // fetch is a read candidate
    logic rd_d;      // data is a read candidate
    logic if_win;    // fetch owns the read port this cycle
    logic d_rd_win;  // data owns the read port this cycle
    logic d_wr_win;  // data write accepted this cycle

    logic [3:0] streak_q, streak_d;

    // Tail of the pipeline is index READ_LAT-1; owner 1 = data, 0 = fetch.
    logic [READ_LAT-1:0] pipe_valid_q;
    logic [READ_LAT-1:0] pipe_owner_q;

    // ------------------------------------------------------------------
    // Arbitration (combinational; everything gated off while rst is high)
    // ------------------------------------------------------------------
    always_comb begin
        rd_if    = bus.if_req;
        rd_d     = bus.d_req && !bus.d_we;
        // Data has priority unless fetch has already waited out the streak.
        if_win   = !rst && rd_if && (!rd_d || (streak_q == StreakMax));
        d_rd_win = !rst && rd_d && !if_win;
        d_wr_win = !rst && bus.d_req && bus.d_we;
    end

    always_comb begin
        streak_d = '0;
        // The streak only grows while fetch is actually being held off.
        if (d_rd_win && rd_if) begin
            streak_d = (streak_q == StreakMax) ? streak_q : streak_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.if_gnt = if_win;
    assign bus.d_gnt  = d_rd_win || d_wr_win;

    assign bus.sram_re    = if_win || d_rd_win;
    assign bus.sram_raddr = if_win   ? bus.if_addr :
                            d_rd_win ? bus.d_addr  : '0;

    assign bus.sram_we    = d_wr_win;
    assign bus.sram_waddr = d_wr_win ? bus.d_addr  : '0;
    assign bus.sram_wdata = d_wr_win ? bus.d_wdata : '0;

    // Both requesters see the raw SRAM data; only rvalid says whose it is.
    assign bus.if_rdata  = bus.sram_rdata;
    assign bus.d_rdata   = bus.sram_rdata;
    assign bus.if_rvalid = pipe_valid_q[READ_LAT-1] && !pipe_owner_q[READ_LAT-1];
    assign bus.d_rvalid  = pipe_valid_q[READ_LAT-1] &&  pipe_owner_q[READ_LAT-1];

    // ------------------------------------------------------------------
    // State: streak counter and return pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q     <= '0;
            pipe_valid_q <= '0;
            pipe_owner_q <= '0;
        end else begin
            streak_q        <= streak_d;
            pipe_valid_q[0] <= if_win || d_rd_win;
            pipe_owner_q[0] <= d_rd_win;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_owner_q[i] <= pipe_owner_q[i-1];
            end
        end
    end

`ifdef CANDY_ARB_PERF_EN
    // ------------------------------------------------------------------
    // Stall counters: one per requester, wrap naturally at 2^32
    // ------------------------------------------------------------------
    logic [31:0] if_stall_q;
    logic [31:0] d_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            if_stall_q <= '0;
            d_stall_q  <= '0;
        end else begin
            if (bus.if_req && !if_win) begin
                if_stall_q <= if_stall_q + 32'd1;
            end
            if (bus.d_req && !(d_rd_win || d_wr_win)) begin
                d_stall_q <= d_stall_q + 32'd1;
            end
        end
    end

    assign bus.if_stall_cnt = if_stall_q;
    assign bus.d_stall_cnt  = d_stall_q;
`endif

endmodule

// File: tb/tb_candy_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_candy_sram_arbiter
//
// Directed steps followed by randomized traffic, checked each cycle against a
// reference model. Two DUTs share the same stimulus: u_dut with READ_LAT = 1
// and u_dut2 with READ_LAT = 2. Returns are predicted from a per-cycle history
// of who was granted and when reset was asserted.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_candy_sram_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXS = 4;
    localparam int          HMAX = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    candy_sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    candy_sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

    assign bus2.if_req     = bus.if_req;
    assign bus2.if_addr    = bus.if_addr;
    assign bus2.d_req      = bus.d_req;
    assign bus2.d_we       = bus.d_we;
    assign bus2.d_addr     = bus.d_addr;
    assign bus2.d_wdata    = bus.d_wdata;
    assign bus2.sram_rdata = bus.sram_rdata;

    candy_sram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .MAX_DATA_STREAK(MAXS)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    candy_sram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .READ_LAT(2), .MAX_DATA_STREAK(MAXS)
    ) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    int          m_streak = 0;       // consecutive data read wins while fetch waits
    logic [1:0]  hist_code [HMAX];   // per cycle: 0 none, 1 fetch read, 2 data read
    bit          hist_rst  [HMAX];
    bit          fw, dw, ww;         // expected fetch read / data read / data write grants
    logic [31:0] m_if_stall = '0;
    logic [31:0] m_d_stall  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // A read granted in cycle k returns in cycle k+lat unless a reset edge
    // falls in between.
    function automatic bit exp_rv(int t, int lat, logic [1:0] owner);
        int k;
        k = t - lat;
        if (k < 0) return 1'b0;
        if (hist_code[k] != owner) return 1'b0;
        for (int j = k + 1; j < t; j++) begin
            if (hist_rst[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_cycle();
        bit rdif, rdd, e;
        @(negedge clk);
        rdif = bus.if_req;
        rdd  = bus.d_req && !bus.d_we;
        if (rst) begin
            fw = 1'b0; dw = 1'b0; ww = 1'b0;
        end else begin
            fw = rdif && (!rdd || (m_streak == int'(MAXS)));
            dw = rdd && !fw;
            ww = bus.d_req && bus.d_we;
        end
        chk("if_gnt", bus.if_gnt, fw);
        chk("d_gnt", bus.d_gnt, dw || ww);
        chk("sram_re", bus.sram_re, fw || dw);
        chk("sram_raddr", bus.sram_raddr, fw ? bus.if_addr : (dw ? bus.d_addr : '0));
        chk("sram_we", bus.sram_we, ww);
        chk("sram_waddr", bus.sram_waddr, ww ? bus.d_addr : '0);
        chk("sram_wdata", bus.sram_wdata, ww ? bus.d_wdata : '0);
        chk("lat2_if_gnt", bus2.if_gnt, fw);
        if (cyc > 0) begin
            e = exp_rv(cyc, 1, 2'd1);
            chk("if_rvalid", bus.if_rvalid, e);
            if (e) chk("if_rdata", bus.if_rdata, bus.sram_rdata);
            e = exp_rv(cyc, 1, 2'd2);
            chk("d_rvalid", bus.d_rvalid, e);
            if (e) chk("d_rdata", bus.d_rdata, bus.sram_rdata);
            chk("lat2_if_rvalid", bus2.if_rvalid, exp_rv(cyc, 2, 2'd1));
            chk("lat2_d_rvalid", bus2.d_rvalid, exp_rv(cyc, 2, 2'd2));
`ifdef CANDY_ARB_PERF_EN
            chk("if_stall_cnt", bus.if_stall_cnt, m_if_stall);
            chk("d_stall_cnt", bus.d_stall_cnt, m_d_stall);
`endif
        end
    endtask

    task automatic advance();
        @(posedge clk);
        hist_rst[cyc]  = rst;
        hist_code[cyc] = fw ? 2'd1 : (dw ? 2'd2 : 2'd0);
        if (rst) begin
            m_if_stall = '0;
            m_d_stall  = '0;
            m_streak   = 0;
        end else begin
            if (bus.if_req && !fw) m_if_stall = m_if_stall + 32'd1;
            if (bus.d_req && !(dw || ww)) m_d_stall = m_d_stall + 32'd1;
            if (dw && bus.if_req) m_streak = (m_streak < int'(MAXS)) ? m_streak + 1 : m_streak;
            else m_streak = 0;
        end
        cyc++;
        #1;
    endtask

    task automatic step();
        check_cycle();
        advance();
    endtask

    initial begin
        // Reset with both requesters asking
        rst = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80; bus.d_wdata = '0;
        bus.sram_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            check_cycle();
            chk("rst_if_gnt", bus.if_gnt, 1'b0);
            chk("rst_d_gnt", bus.d_gnt, 1'b0);
            chk("rst_sram_re", bus.sram_re, 1'b0);
            chk("rst_sram_we", bus.sram_we, 1'b0);
            advance();
        end
        rst = 1'b0;
        check_cycle();
        chk("first_d_gnt", bus.d_gnt, 1'b1);
        chk("first_if_gnt", bus.if_gnt, 1'b0);
        advance();

        // Pending fetch (0x40) goes through alone
        bus.d_req = 1'b0;
        step();

        // Fetch only: 0x100, data returns next cycle
        bus.if_addr = 32'h100;
        check_cycle();
        chk("fo_if_gnt", bus.if_gnt, 1'b1);
        chk("fo_raddr", bus.sram_raddr, 32'h100);
        advance();
        bus.if_req = 1'b0;
        bus.sram_rdata = 32'hDEADBEEF;
        check_cycle();
        chk("fo_if_rvalid", bus.if_rvalid, 1'b1);
        chk("fo_if_rdata", bus.if_rdata, 32'hDEADBEEF);
        chk("fo_d_rvalid", bus.d_rvalid, 1'b0);
        advance();

        // Contention from a fresh reset: D,D,D,D,I,D,D,D,D,I
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h1000;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2000;
        for (int i = 0; i < 10; i++) begin
            check_cycle();
            chk("cont_if_gnt", bus.if_gnt, (i == 4) || (i == 9));
            chk("cont_d_gnt", bus.d_gnt, !((i == 4) || (i == 9)));
            if (i > 0) chk("cont_ret_if", bus.if_rvalid, (i == 5));
            advance();
            if (fw) bus.if_addr = bus.if_addr + 32'd4;
            if (dw) bus.d_addr = bus.d_addr + 32'd4;
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        check_cycle();
        chk("cont_ret_last_if", bus.if_rvalid, 1'b1);
`ifdef CANDY_ARB_PERF_EN
        chk("perf_if_stall", bus.if_stall_cnt, 32'd8);
        chk("perf_d_stall", bus.d_stall_cnt, 32'd2);
`endif
        advance();

        // Concurrent write and fetch read
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678;
        bus.if_req = 1'b1; bus.if_addr = 32'h104;
        check_cycle();
        chk("cw_if_gnt", bus.if_gnt, 1'b1);
        chk("cw_d_gnt", bus.d_gnt, 1'b1);
        chk("cw_we", bus.sram_we, 1'b1);
        chk("cw_waddr", bus.sram_waddr, 32'h200);
        chk("cw_wdata", bus.sram_wdata, 32'h12345678);
        chk("cw_raddr", bus.sram_raddr, 32'h104);
        chk("cw_re", bus.sram_re, 1'b1);
        advance();

        // Mid-flight reset on the READ_LAT = 2 instance
        bus.if_req = 1'b0;
        bus.d_we = 1'b0; bus.d_addr = 32'h300;
        step();
        bus.d_req = 1'b0;
        rst = 1'b1;
        check_cycle();
        chk("mid_lat2_d_rvalid", bus2.d_rvalid, 1'b0);
        advance();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_cycle();
            chk("mid_lat2_d_rvalid", bus2.d_rvalid, 1'b0);
            advance();
        end

        // Randomized traffic; requests are held until granted
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            bus.sram_rdata = $urandom();
            step();
            if (!bus.if_req || fw) begin
                bus.if_req  = ($urandom_range(0, 2) != 0);
                bus.if_addr = $urandom();
            end
            if (!bus.d_req || dw || ww) begin
                bus.d_req   = ($urandom_range(0, 2) != 0);
                bus.d_we    = ($urandom_range(0, 2) == 0);
                bus.d_addr  = $urandom();
                bus.d_wdata = $urandom();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
